// File: rtl/atm_session_arbiter.sv
// Round-robin arbiter sharing one ATM core among N_TERM card-reader terminals.
// Sequences core reset around each session and locks terminals after repeated failures.
module atm_session_arbiter #(
    parameter int N_TERM    = 4,
    parameter int TIMEOUT   = 64,
    parameter int MAX_TRIES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_TERM-1:0]      req,
    input  logic [3*N_TERM-1:0]    op_in,
    input  logic [4*N_TERM-1:0]    acc_in,
    input  logic [16*N_TERM-1:0]   pin_in,
    input  logic [16*N_TERM-1:0]   newpin_in,
    input  logic [16*N_TERM-1:0]   amount_in,
    input  logic [N_TERM-1:0]      lang_in,
    output logic [N_TERM-1:0]      grant,
    output logic [N_TERM-1:0]      done,
    output logic                   result_ok,
    output logic [15:0]            result_balance,
    output logic [N_TERM-1:0]      locked,
    output logic                   core_rst,
    output logic [2:0]             core_operation,
    output logic [3:0]             core_acc_num,
    output logic [15:0]            core_pin,
    output logic [15:0]            core_newpin,
    output logic [15:0]            core_amount,
    output logic                   core_language,
    input  logic [15:0]            core_balance,
    input  logic                   core_success
);

    localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gidx;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] fail_cnt [N_TERM];

    logic [N_TERM-1:0] eligible;
    logic              found;
    logic [IDX_W-1:0]  pick;
    logic              req_g;

    logic [2:0]  sel_op;
    logic [3:0]  sel_acc;
    logic [15:0] sel_pin;
    logic [15:0] sel_newpin;
    logic [15:0] sel_amount;
    logic        sel_lang;

    function automatic logic [N_TERM-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_TERM-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign eligible = req & ~locked;
    assign req_g    = req[gidx];

    // Search starts one past the last served terminal and wraps around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_TERM; k++) begin
            for (int i = 0; i < N_TERM; i++) begin
                if (!found && eligible[i] && (((int'(rr_ptr) + k) % N_TERM) == i)) begin
                    found = 1'b1;
                    pick  = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_op     = '0;
        sel_acc    = '0;
        sel_pin    = '0;
        sel_newpin = '0;
        sel_amount = '0;
        sel_lang   = 1'b0;
        for (int i = 0; i < N_TERM; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_op     = op_in[3*i +: 3];
                sel_acc    = acc_in[4*i +: 4];
                sel_pin    = pin_in[16*i +: 16];
                sel_newpin = newpin_in[16*i +: 16];
                sel_amount = amount_in[16*i +: 16];
                sel_lang   = lang_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rr_ptr         <= IDX_W'(N_TERM - 1);
            gidx           <= '0;
            timer          <= '0;
            grant          <= '0;
            done           <= '0;
            result_ok      <= 1'b0;
            result_balance <= '0;
            locked         <= '0;
            core_rst       <= 1'b1;
            core_operation <= '0;
            core_acc_num   <= '0;
            core_pin       <= '0;
            core_newpin    <= '0;
            core_amount    <= '0;
            core_language  <= 1'b0;
            for (int i = 0; i < N_TERM; i++) begin
                fail_cnt[i] <= '0;
            end
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    core_rst <= 1'b1;
                    if (found) begin
                        gidx           <= pick;
                        grant          <= onehot(pick);
                        core_operation <= sel_op;
                        core_acc_num   <= sel_acc;
                        core_pin       <= sel_pin;
                        core_newpin    <= sel_newpin;
                        core_amount    <= sel_amount;
                        core_language  <= sel_lang;
                        state          <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    timer    <= '0;
                    core_rst <= 1'b0;
                    state    <= S_RUN;
                end

                // A dropped request outranks a result arriving in the same cycle.
                S_RUN: begin
                    if (!req_g) begin
                        grant    <= '0;
                        core_rst <= 1'b1;
                        state    <= S_RELEASE;
                    end else if (core_success) begin
                        result_ok      <= 1'b1;
                        result_balance <= core_balance;
                        done           <= onehot(gidx);
                        core_rst       <= 1'b1;
                        state          <= S_REPORT;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        result_ok      <= 1'b0;
                        result_balance <= core_balance;
                        done           <= onehot(gidx);
                        core_rst       <= 1'b1;
                        state          <= S_REPORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_REPORT: begin
                    grant  <= '0;
                    rr_ptr <= gidx;
                    if (result_ok) begin
                        fail_cnt[gidx] <= '0;
                    end else if (fail_cnt[gidx] < CNT_W'(MAX_TRIES)) begin
                        fail_cnt[gidx] <= fail_cnt[gidx] + 1'b1;
                        if (fail_cnt[gidx] == CNT_W'(MAX_TRIES - 1)) begin
                            locked[gidx] <= 1'b1;
                        end
                    end
                    state <= S_RELEASE;
                end

                S_RELEASE: begin
                    grant    <= '0;
                    core_rst <= 1'b1;
                    rr_ptr   <= gidx;
                    if (!req_g) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    grant    <= '0;
                    core_rst <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/atm_session_arbiter.md
Name: atm_session_arbiter

Overview:
Shares one ATM core among N_TERM terminal front-ends (card readers).
- Picks a requesting terminal round-robin and latches that terminal's transaction fields.
- Holds the core in reset while idle, releases it to run the session, and watches core_success with a timeout.
- Returns the result and balance to the granted terminal.
- Tracks consecutive failed sessions per terminal and locks out a terminal after MAX_TRIES failures.

Parameters:
N_TERM, 4, number of terminals (2..8)
TIMEOUT, 64, RUN cycles allowed before a session fails (>=2)
MAX_TRIES, 3, consecutive failed sessions before a terminal locks (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  N_TERM  per-terminal session request, level
op_in  in  3*N_TERM  operation code; terminal i uses bits [3i+2:3i]
acc_in  in  4*N_TERM  account number per terminal
pin_in  in  16*N_TERM  PIN per terminal
newpin_in  in  16*N_TERM  new PIN per terminal
amount_in  in  16*N_TERM  amount per terminal
lang_in  in  N_TERM  language select per terminal
grant  out  N_TERM  one-hot grant, registered
done  out  N_TERM  one-cycle completion pulse to the granted terminal
result_ok  out  1  session succeeded; valid while done!=0
result_balance  out  16  core balance captured at session end; valid while done!=0
locked  out  N_TERM  terminal locked out
core_rst  out  1  active-high reset to the ATM core
core_operation  out  3  to core operation
core_acc_num  out  4  to core acc_num
core_pin  out  16  to core pin
core_newpin  out  16  to core newPin
core_amount  out  16  to core amount
core_language  out  1  to core language
core_balance  in  16  from core balance
core_success  in  1  from core success

Behaviour:
Output registration and reset values
- All outputs are registered.
- Reset values: grant=0, done=0, result_ok=0, result_balance=0, locked=0, core_rst=1, all core_* field outputs 0.
- Reset also sets: state=IDLE, rr_ptr=N_TERM-1 (so terminal 0 has first priority), timer=0, every fail counter=0.
- rst asserted mid-session aborts immediately: no done pulse, and locks are cleared.

States: IDLE, LOAD, RUN, REPORT, RELEASE.

IDLE
- core_rst=1. Eligible set = req & ~locked.
- Search starts at rr_ptr+1 with wrap-around, and takes the first eligible index g.
- If one is found: grant[g]=1 on the next edge, latch g's fields into holding registers, then go to LOAD.
- If none is found, stay in IDLE.

LOAD (one cycle)
- core_rst=1 and core_* driven from the latched fields.
- timer cleared; next state RUN.
- Terminal inputs may change after the latch without effect.

RUN
- core_rst=0, latched fields held on the core_* outputs.
- Each cycle, evaluated in priority order:
  - req[g]==0 → abort: go to RELEASE, no done pulse, fail counter unchanged.
  - core_success==1 → capture core_balance, ok=1, go to REPORT.
  - timer==TIMEOUT-1 → capture core_balance, ok=0, go to REPORT.
  - Otherwise timer increments.
- Timer width is clog2(TIMEOUT+1).

REPORT (one cycle)
- done[g]=1; result_ok and result_balance are valid this cycle.
- core_rst=1 again and grant[g] is still held.
- Fail counter g: cleared on ok; incremented on fail, saturating at MAX_TRIES.
- On the increment that reaches MAX_TRIES, locked[g] sets in the same edge that exits REPORT.
- Next state RELEASE.

RELEASE
- grant=0, core_rst=1, rr_ptr=g.
- Stay until req[g]==0, then go to IDLE. The terminal must drop req after done before it can be re-arbitrated.
- A locked terminal still passes through this handshake.

Latency
- req seen in IDLE at edge t → grant at t+1 (LOAD) → RUN starts at t+2.
- core_success seen at RUN edge t+k → done at edge t+k+1.
- Timeout case: done follows TIMEOUT RUN cycles.

Locking and simultaneous events
- locked[i] clears only on rst.
- A locked terminal's req is ignored in IDLE.
- Simultaneous requests: only the round-robin winner is granted; the others wait with req held.
- Fairness: after serving g, every other eligible requester is served before g again.
- done and grant are zero outside REPORT and outside LOAD..REPORT respectively. At most one bit is set in each.

Test Plan:
1. Reset then single request: rst high 2 cycles, then req=0001, op=3, acc=1, pin=1234, amount=90; core model raises core_success 3 cycles into RUN with balance=410.
   → grant=0001 one cycle after req; core_rst low only in RUN; done=0001 with result_ok=1, result_balance=410; grant=0 after terminal drops req.
2. Round-robin: req=1111 held, each session succeeding.
   → grant sequence 0001, 0010, 0100, 1000, 0001; no terminal granted twice before the others.
3. Timeout and lockout: TIMEOUT=64, MAX_TRIES=3, terminal 2 requests three times, core_success never asserted.
   → each done arrives 64 RUN cycles after RUN entry with result_ok=0; after the third, locked=0100; a fourth req[2] is never granted while req[0] is still served.
4. Success resets the fail count: terminal 1 fails twice, then succeeds, then fails twice.
   → locked[1] stays 0 throughout.
5. Abort: req[3] dropped in the 2nd RUN cycle.
   → no done pulse; grant clears; core_rst=1 the next cycle; FSM back in IDLE; fail count for terminal 3 unchanged.
6. Reset mid-RUN: assert rst asynchronously during RUN with locked=0100.
   → grant, done and locked all go to 0 and core_rst goes to 1 immediately; the next arbitration starts from terminal 0.
